// File: rtl/song_pkg.sv
// Shared constants for the birthday-song player: note half-periods at 12 MHz,
// table entry layout and the sequencer state encoding.
package song_pkg;

  localparam int unsigned PW_DEF  = 20;
  localparam int unsigned DUR_W   = 4;
  localparam int unsigned ENTRY_W = PW_DEF + DUR_W;
  localparam int unsigned IDX_W   = 5;

  // Speaker half-periods in clocks: 12e6 / (2 * f_note)
  localparam logic [PW_DEF-1:0] NOTE_REST = 20'd0;
  localparam logic [PW_DEF-1:0] NOTE_C4   = 20'd22933;
  localparam logic [PW_DEF-1:0] NOTE_D4   = 20'd20431;
  localparam logic [PW_DEF-1:0] NOTE_E4   = 20'd18202;
  localparam logic [PW_DEF-1:0] NOTE_F4   = 20'd17181;
  localparam logic [PW_DEF-1:0] NOTE_G4   = 20'd15306;
  localparam logic [PW_DEF-1:0] NOTE_A4   = 20'd13636;
  localparam logic [PW_DEF-1:0] NOTE_B4   = 20'd12149;
  localparam logic [PW_DEF-1:0] NOTE_C5   = 20'd11467;
  localparam logic [PW_DEF-1:0] NOTE_D5   = 20'd10216;
  localparam logic [PW_DEF-1:0] NOTE_E5   = 20'd9101;
  localparam logic [PW_DEF-1:0] NOTE_F5   = 20'd8590;
  localparam logic [PW_DEF-1:0] NOTE_G5   = 20'd7653;
  localparam logic [PW_DEF-1:0] NOTE_A5   = 20'd6818;
  localparam logic [PW_DEF-1:0] NOTE_B5   = 20'd6074;
  localparam logic [PW_DEF-1:0] NOTE_C6   = 20'd5733;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_PLAY  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // A zero duration plays as one unit
  function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous note table, one-cycle read latency. TABLE_SEL=0 is the birthday
// song; TABLE_SEL=1 is a three-entry tune used for short simulations.
module song_rom
  import song_pkg::*;
#(
  parameter int unsigned SONG_LEN  = 25,
  parameter int unsigned PW        = 20,
  parameter int unsigned TABLE_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] addr,
  output logic [PW-1:0]    period,
  output logic [DUR_W-1:0] dur
);

  localparam int unsigned EW = PW + DUR_W;

  logic [EW-1:0] entry_c;

  always_comb begin
    entry_c = '0;
    if (TABLE_SEL == 1) begin
      case (addr)
        5'd0:    entry_c = {PW'(100), 4'd1};
        5'd1:    entry_c = {PW'(0),   4'd2};
        5'd2:    entry_c = {PW'(50),  4'd0};
        default: entry_c = '0;
      endcase
    end else begin
      case (addr)
        5'd0:    entry_c = {PW'(NOTE_G4), 4'd3};
        5'd1:    entry_c = {PW'(NOTE_G4), 4'd1};
        5'd2:    entry_c = {PW'(NOTE_A4), 4'd4};
        5'd3:    entry_c = {PW'(NOTE_G4), 4'd4};
        5'd4:    entry_c = {PW'(NOTE_C5), 4'd4};
        5'd5:    entry_c = {PW'(NOTE_B4), 4'd8};
        5'd6:    entry_c = {PW'(NOTE_G4), 4'd3};
        5'd7:    entry_c = {PW'(NOTE_G4), 4'd1};
        5'd8:    entry_c = {PW'(NOTE_A4), 4'd4};
        5'd9:    entry_c = {PW'(NOTE_G4), 4'd4};
        5'd10:   entry_c = {PW'(NOTE_D5), 4'd4};
        5'd11:   entry_c = {PW'(NOTE_C5), 4'd8};
        5'd12:   entry_c = {PW'(NOTE_G4), 4'd3};
        5'd13:   entry_c = {PW'(NOTE_G4), 4'd1};
        5'd14:   entry_c = {PW'(NOTE_G5), 4'd4};
        5'd15:   entry_c = {PW'(NOTE_E5), 4'd4};
        5'd16:   entry_c = {PW'(NOTE_C5), 4'd4};
        5'd17:   entry_c = {PW'(NOTE_B4), 4'd4};
        5'd18:   entry_c = {PW'(NOTE_A4), 4'd8};
        5'd19:   entry_c = {PW'(NOTE_F5), 4'd3};
        5'd20:   entry_c = {PW'(NOTE_F5), 4'd1};
        5'd21:   entry_c = {PW'(NOTE_E5), 4'd4};
        5'd22:   entry_c = {PW'(NOTE_C5), 4'd4};
        5'd23:   entry_c = {PW'(NOTE_D5), 4'd4};
        5'd24:   entry_c = {PW'(NOTE_C5), 4'd8};
        default: entry_c = '0;
      endcase
    end
    if (32'(addr) >= SONG_LEN) entry_c = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= '0;
      dur    <= '0;
    end else begin
      {period, dur} <= entry_c;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Steps through the note table, hands each half-period to the tone generator,
// holds it for its duration, then inserts a silent gap. SONG_LOOP_EN repeats the song.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned SONG_LEN    = 25,
  parameter int unsigned PW          = 20,
  parameter int unsigned UNIT_CYCLES = 750_000,
  parameter int unsigned GAP_CYCLES  = 60_000,
  parameter int unsigned TABLE_SEL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             note_ready,
  output logic             note_valid,
  output logic [PW-1:0]    note_period,
  output logic             tone_en,
  output logic [IDX_W-1:0] note_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned HW = $clog2(15 * UNIT_CYCLES);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  state_t           state_q, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [HW-1:0]    hold_q, hold_nxt;
  logic [GW-1:0]    gap_q, gap_nxt;
  logic [PW-1:0]    period_nxt;
  logic [PW-1:0]    rom_period;
  logic [DUR_W-1:0] rom_dur;

  // ROM is addressed with the upcoming index so the entry is ready during FETCH
  song_rom #(
    .SONG_LEN (SONG_LEN),
    .PW       (PW),
    .TABLE_SEL(TABLE_SEL)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .addr  (idx_nxt),
    .period(rom_period),
    .dur   (rom_dur)
  );

  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = note_idx;
    hold_nxt   = hold_q;
    gap_nxt    = gap_q;
    period_nxt = note_period;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
        end
      end
      ST_FETCH: begin
        state_nxt  = ST_LOAD;
        period_nxt = rom_period;
      end
      ST_LOAD: begin
        if (note_ready) begin
          state_nxt = ST_PLAY;
          hold_nxt  = HW'(32'(dur_eff(rom_dur)) * UNIT_CYCLES - 32'd1);
        end
      end
      ST_PLAY: begin
        if (hold_q == '0) begin
          state_nxt = ST_GAP;
          gap_nxt   = GW'(GAP_CYCLES - 1);
        end else begin
          hold_nxt = hold_q - HW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          if (note_idx == LAST_IDX) begin
`ifdef SONG_LOOP_EN
            state_nxt = ST_FETCH;
            idx_nxt   = '0;
`else
            state_nxt = ST_DONE;
`endif
          end else begin
            state_nxt = ST_FETCH;
            idx_nxt   = note_idx + IDX_W'(1);
          end
        end else begin
          gap_nxt = gap_q - GW'(1);
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (stop && state_q != ST_IDLE) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end
    if (state_nxt == ST_IDLE) period_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      note_idx    <= '0;
      hold_q      <= '0;
      gap_q       <= '0;
      note_valid  <= 1'b0;
      note_period <= '0;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      note_idx    <= idx_nxt;
      hold_q      <= hold_nxt;
      gap_q       <= gap_nxt;
      note_valid  <= (state_nxt == ST_LOAD);
      note_period <= period_nxt;
      tone_en     <= (state_nxt == ST_PLAY) && (period_nxt != '0);
      busy        <= (state_nxt != ST_IDLE);
      done        <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: expected per-cycle outputs are derived from the note
// table and timing rules, with randomized handshake stalls, start pulses and stops.
`timescale 1ns/1ps
module tb_song_sequencer;

  localparam int unsigned PW   = 20;
  localparam int unsigned UNIT = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned LEN  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          note_ready = 1'b0;
  logic          note_valid;
  logic [PW-1:0] note_period;
  logic          tone_en;
  logic [4:0]    note_idx;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  song_sequencer #(
    .SONG_LEN   (LEN),
    .PW         (PW),
    .UNIT_CYCLES(UNIT),
    .GAP_CYCLES (GAP),
    .TABLE_SEL  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .note_ready (note_ready),
    .note_valid (note_valid),
    .note_period(note_period),
    .tone_en    (tone_en),
    .note_idx   (note_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Phase tags: 0 fetch, 1 load, 2 play, 3 gap, 4 done, 5 idle
  typedef struct {
    logic          start, stop, ready;
    logic          valid, tone, busy, done;
    logic          chk_p, chk_i;
    logic [PW-1:0] period;
    logic [4:0]    idx;
    int            ph;
  } cyc_t;

  cyc_t tl[$];
  int   tbl_p[LEN] = '{100, 0, 50};
  int   tbl_d[LEN] = '{1, 2, 0};

  function automatic cyc_t mk(input int ph, input logic v, input logic t, input logic b,
                              input logic d, input int p, input int i,
                              input logic cp, input logic ci);
    cyc_t c;
    c.ph = ph; c.valid = v; c.tone = t; c.busy = b; c.done = d;
    c.period = PW'(p); c.idx = 5'(i); c.chk_p = cp; c.chk_i = ci;
    c.stop = 1'b0;
    c.ready = 1'($urandom);
    c.start = b ? 1'($urandom) : 1'b0;
    return c;
  endfunction

  task automatic apply_stop(input int at);
    while (tl.size() > at + 1) void'(tl.pop_back());
    tl[at].stop = 1'b1;
    for (int j = 0; j < 3; j++) tl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 1, 1));
  endtask

  // Expected timeline of one playback: fetch, load (+stalls), hold, gap per entry
  task automatic build(input int stall_max, input int forced);
    int last_p, passes, hold, stall;
    cyc_t c;
    tl.delete();
    last_p = 0;
`ifdef SONG_LOOP_EN
    passes = 2;
`else
    passes = 1;
`endif
    for (int ps = 0; ps < passes; ps++) begin
      for (int i = 0; i < int'(LEN); i++) begin
        tl.push_back(mk(0, 0, 0, 1, 0, last_p, i, 1, 1));
        stall = (forced >= 0 && ps == 0 && i == 0) ? forced : int'($urandom_range(0, stall_max));
        for (int s = 0; s <= stall; s++) begin
          c = mk(1, 1, 0, 1, 0, tbl_p[i], i, 1, 1);
          c.ready = (s == stall);
          tl.push_back(c);
        end
        hold = ((tbl_d[i] == 0) ? 1 : tbl_d[i]) * int'(UNIT);
        for (int h = 0; h < hold; h++) tl.push_back(mk(2, 0, tbl_p[i] != 0, 1, 0, tbl_p[i], i, 1, 1));
        for (int g = 0; g < int'(GAP); g++) tl.push_back(mk(3, 0, 0, 1, 0, tbl_p[i], i, 1, 1));
        last_p = tbl_p[i];
      end
    end
`ifdef SONG_LOOP_EN
    apply_stop(tl.size() - 1);
`else
    tl.push_back(mk(4, 0, 0, 1, 1, 0, LEN - 1, 0, 1));
    tl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 1, 0));
`endif
  endtask

  function automatic logic [28:0] expv(input int k);
    return {tl[k].valid, tl[k].tone, tl[k].busy, tl[k].done,
            tl[k].chk_p ? tl[k].period : {PW{1'b0}}, tl[k].chk_i ? tl[k].idx : 5'd0};
  endfunction

  function automatic string fmt(input logic [28:0] v);
    return $sformatf("valid=%b tone=%b busy=%b done=%b period=%0d idx=%0d",
                     v[28], v[27], v[26], v[25], v[24:5], v[4:0]);
  endfunction

  task automatic kick();
    @(negedge clk);
    start = 1'b1; stop = 1'b0; note_ready = 1'($urandom);
  endtask

  task automatic step(input int k, output logic [28:0] obs);
    @(negedge clk);
    obs = {note_valid, tone_en, busy, done,
           tl[k].chk_p ? note_period : {PW{1'b0}}, tl[k].chk_i ? note_idx : 5'd0};
    start = tl[k].start; stop = tl[k].stop; note_ready = tl[k].ready;
  endtask

  task automatic test_reset();
    logic [28:0] o;
    #1;
    n_tests++;
    if ({note_valid, tone_en, busy, done, note_period, note_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got %s, expected all zero", fmt({note_valid, tone_en, busy, done, note_period, note_idx}));
    end
    @(negedge clk); rst = 1'b1;
    build(0, -1);
    kick();
    for (int k = 0; k < 4; k++) begin
      step(k, o);
      n_tests++;
      if (o !== expv(k)) begin
        n_fail++;
        $display("FAIL reset_pre cycle %0d phase %0d: got %s, expected %s", k, tl[k].ph, fmt(o), fmt(expv(k)));
      end
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({note_valid, tone_en, busy, done, note_period, note_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %s, expected all zero", fmt({note_valid, tone_en, busy, done, note_period, note_idx}));
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({note_valid, tone_en, busy, done, note_period, note_idx} !== '0) begin
        n_fail++;
        $display("FAIL reset_release: got %s, expected idle zeros", fmt({note_valid, tone_en, busy, done, note_period, note_idx}));
      end
    end
  endtask

  task automatic test_full_play();
    logic [28:0] o;
    build(0, -1);
    kick();
    foreach (tl[k]) begin
      step(k, o);
      n_tests++;
      if (o !== expv(k)) begin
        n_fail++;
        $display("FAIL full_play cycle %0d phase %0d: got %s, expected %s", k, tl[k].ph, fmt(o), fmt(expv(k)));
      end
    end
  endtask

  task automatic test_handshake_stall();
    logic [28:0] o;
    build(2, 5);
    kick();
    foreach (tl[k]) begin
      step(k, o);
      n_tests++;
      if (o !== expv(k)) begin
        n_fail++;
        $display("FAIL stall cycle %0d phase %0d: got %s, expected %s", k, tl[k].ph, fmt(o), fmt(expv(k)));
      end
    end
  endtask

  task automatic test_stop();
    logic [28:0] o;
    int at;
    build(2, -1);
    at = -1;
    foreach (tl[k]) if (at < 0 && tl[k].ph == 2 && tl[k].idx == 5'd1) at = k + 2;
    apply_stop(at);
    kick();
    foreach (tl[k]) begin
      step(k, o);
      n_tests++;
      if (o !== expv(k)) begin
        n_fail++;
        $display("FAIL stop cycle %0d phase %0d: got %s, expected %s", k, tl[k].ph, fmt(o), fmt(expv(k)));
      end
    end
    build(1, -1);
    kick();
    foreach (tl[k]) begin
      step(k, o);
      n_tests++;
      if (o !== expv(k)) begin
        n_fail++;
        $display("FAIL replay cycle %0d phase %0d: got %s, expected %s", k, tl[k].ph, fmt(o), fmt(expv(k)));
      end
    end
  endtask

  task automatic test_collisions();
    logic [28:0] o;
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({note_valid, tone_en, busy, done, note_period} !== '0) begin
        n_fail++;
        $display("FAIL start_stop_idle: got %s, expected idle", fmt({note_valid, tone_en, busy, done, note_period, note_idx}));
      end
    end
    start = 1'b0; stop = 1'b0;
    build(1, -1);
    foreach (tl[k]) if (tl[k].busy) tl[k].start = 1'b1;
    kick();
    foreach (tl[k]) begin
      step(k, o);
      n_tests++;
      if (o !== expv(k)) begin
        n_fail++;
        $display("FAIL start_while_busy cycle %0d phase %0d: got %s, expected %s", k, tl[k].ph, fmt(o), fmt(expv(k)));
      end
    end
  endtask

  task automatic test_random();
    logic [28:0] o;
    for (int r = 0; r < 6; r++) begin
      build(int'($urandom_range(0, 4)), -1);
      if ($urandom_range(0, 1) == 1) apply_stop(int'($urandom_range(0, tl.size() - 2)));
      kick();
      foreach (tl[k]) begin
        step(k, o);
        n_tests++;
        if (o !== expv(k)) begin
          n_fail++;
          $display("FAIL random%0d cycle %0d phase %0d: got %s, expected %s", r, k, tl[k].ph, fmt(o), fmt(expv(k)));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b0;
    test_reset();
    test_full_play();
    test_handshake_stall();
    test_stop();
    test_collisions();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
